bus_uart_tx: RTL and testbench

Memory-mapped UART transmitter that sits downstream of the system bus as an additional device, next to RAM, simulator control and timer. It takes byte writes from the core's data port into a transmit FIFO and serialises them as 8N1 frames on a single output line. It also provides status readback and a FIFO-empty interrupt for the core's fast-interrupt inputs. Register window is 1 kB, decoded on address bits [9:2].

---
 rtl/bus_uart_tx.sv | 265 ++++++++++++++++++++++++++
 tb/tb_bus_uart_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_uart_tx.sv
// bus_uart_tx
// Memory-mapped 8N1 UART transmitter on the system bus.
// Bytes written to TXDATA go into a small FIFO and are serialised LSB first
// on tx_o. Status, clock divisor and control are readable over the bus, and
// irq_o can signal that all queued data has been sent.
//
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   dev_req_i         : bus request (always granted in the same cycle)
//   dev_we_i          : write enable
//   dev_be_i          : byte enables
//   dev_addr_i        : byte address, only [9:2] is decoded
//   dev_wdata_i       : write data
//   dev_rvalid_o      : response valid, one cycle after every request
//   dev_rdata_o       : read data (0 unless a valid read response)
//   dev_err_o         : error response for unmapped offsets
//   tx_o              : serial output, idle high
//   irq_o             : level interrupt, irq_en & fifo empty & not busy
//   dbg_state_o       : current transmit FSM state, for observation
//
// Register map (byte offsets):
//   0x0 TXDATA  W   be[0] pushes wdata[7:0]; reads 0
//   0x4 STATUS  R   [0] full [1] empty [2] busy [3] overflow [11:8] level
//   0x8 CLKDIV  RW  [15:0] cycles per bit, 0 behaves as 1
//   0xC CTRL    RW  [0] irq_en, [1] write 1 clears overflow (reads 0)

module bus_uart_tx #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned FifoDepth    = 8,
  parameter logic [15:0] ClkDivReset  = 16'd868
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dev_req_i,
  input  logic                    dev_we_i,
  input  logic [3:0]              dev_be_i,
  input  logic [AddressWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0]    dev_wdata_i,
  output logic                    dev_rvalid_o,
  output logic [DataWidth-1:0]    dev_rdata_o,
  output logic                    dev_err_o,
  output logic                    tx_o,
  output logic                    irq_o,
  output logic [1:0]              dbg_state_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // Bus handshake: a request with dev_req_i=1 is accepted in the cycle it is
  // presented (there is no stall). Exactly one cycle later dev_rvalid_o=1
  // with dev_rdata_o/dev_err_o for that request; both are 0 in any cycle
  // where dev_rvalid_o=0. Back-to-back requests get back-to-back responses.

  // ---------------------------------------------------------------- decode
  logic [7:0] w_word;
  logic       w_sel_tx;
  logic       w_sel_status;
  logic       w_sel_clkdiv;
  logic       w_sel_ctrl;
  logic       w_bad;
  logic       w_wr;

  assign w_word       = dev_addr_i[9:2];
  assign w_sel_tx     = (w_word == 8'd0);
  assign w_sel_status = (w_word == 8'd1);
  assign w_sel_clkdiv = (w_word == 8'd2);
  assign w_sel_ctrl   = (w_word == 8'd3);
  assign w_bad        = (w_word > 8'd3);
  assign w_wr         = dev_req_i & dev_we_i;

  // Bits of the bus that carry no meaning for this device.
  logic w_unused;
  assign w_unused = ^{dev_addr_i[AddressWidth-1:10], dev_addr_i[1:0],
                      dev_wdata_i[DataWidth-1:16], dev_be_i[3:2]};

  // ------------------------------------------------------------- registers
  logic [15:0]    r_clkdiv;
  logic           r_irq_en;
  logic           r_ovf;
  logic           r_irq;

  // ------------------------------------------------------------------ fifo
  logic [7:0]     r_mem [FifoDepth];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [LvlW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push_req;
  logic w_push;
  logic w_ovf_set;
  logic w_ovf_clr;
  logic w_pop;

  assign w_full     = (r_count == LvlW'(FifoDepth));
  assign w_empty    = (r_count == '0);
  assign w_push_req = w_wr & w_sel_tx & dev_be_i[0];
  // Fullness is judged before the edge: a pop in the same cycle does not
  // make room for the push.
  assign w_push     = w_push_req & ~w_full;
  assign w_ovf_set  = w_push_req & w_full;
  assign w_ovf_clr  = w_wr & w_sel_ctrl & dev_be_i[0] & dev_wdata_i[1];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= dev_wdata_i[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------- tx fsm
  tx_state_e   r_state;
  tx_state_e   w_state_next;
  logic [7:0]  r_shift;
  logic [15:0] r_div;      // divisor latched at frame start
  logic [15:0] r_bit_cnt;  // cycles left in the current bit
  logic [2:0]  r_bit_idx;
  logic [15:0] w_div_eff;
  logic        w_bit_done;
  logic        w_busy;

  assign w_div_eff  = (r_clkdiv == 16'd0) ? 16'd1 : r_clkdiv;
  assign w_bit_done = (r_bit_cnt == 16'd1);
  assign w_busy     = (r_state != S_IDLE);

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_done) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_bit_done && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_bit_done) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_div     <= 16'd1;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_shift   <= r_mem[r_rptr];
        r_div     <= w_div_eff;
        r_bit_cnt <= w_div_eff;
        r_bit_idx <= '0;
      end else if (w_busy) begin
        if (w_bit_done) begin
          r_bit_cnt <= r_div;
          if (r_state == S_DATA) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt - 16'd1;
        end
      end
    end
  end

  assign tx_o        = (r_state == S_START) ? 1'b0 :
                       (r_state == S_DATA)  ? r_shift[0] : 1'b1;
  assign dbg_state_o = r_state;

  // ------------------------------------------------- control registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_clkdiv <= ClkDivReset;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && w_sel_clkdiv) begin
        if (dev_be_i[0]) r_clkdiv[7:0]  <= dev_wdata_i[7:0];
        if (dev_be_i[1]) r_clkdiv[15:8] <= dev_wdata_i[15:8];
      end
      if (w_wr && w_sel_ctrl && dev_be_i[0]) r_irq_en <= dev_wdata_i[0];
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      r_irq <= r_irq_en & w_empty & ~w_busy;
    end
  end

  assign irq_o = r_irq;

  // ------------------------------------------------------- read / response
  logic [DataWidth-1:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    if (w_sel_status) begin
      w_rdata[0]           = w_full;
      w_rdata[1]           = w_empty;
      w_rdata[2]           = w_busy;
      w_rdata[3]           = r_ovf;
      w_rdata[8 +: LvlW]   = r_count;
    end else if (w_sel_clkdiv) begin
      w_rdata[15:0] = r_clkdiv;
    end else if (w_sel_ctrl) begin
      w_rdata[0] = r_irq_en;
    end
  end

  logic                 r_rvalid;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= dev_req_i;
      r_err    <= dev_req_i & w_bad;
      r_rdata  <= (dev_req_i && !dev_we_i) ? w_rdata : '0;
    end
  end

  assign dev_rvalid_o = r_rvalid;
  assign dev_rdata_o  = r_rdata;
  assign dev_err_o    = r_err;

endmodule

// File: tb/tb_bus_uart_tx.sv
module tb_bus_uart_tx;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  // ---------------------------------------------------- clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  be  = 4'h0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        tx;
  logic        irq;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  bus_uart_tx #(
    .DataWidth(32), .AddressWidth(32), .FifoDepth(8), .ClkDivReset(16'd868)
  ) dut (
    .clk_i(clk), .rst_i(rst), .dev_req_i(req), .dev_we_i(we), .dev_be_i(be),
    .dev_addr_i(addr), .dev_wdata_i(wdata), .dev_rvalid_o(rvalid),
    .dev_rdata_o(rdata), .dev_err_o(err), .tx_o(tx), .irq_o(irq),
    .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // ---------------------------------------------------- drivers
  task automatic bus_idle();
    req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
  endtask

  // One request in cycle N; response sampled mid cycle N+1.
  task automatic bus_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b, output logic [31:0] rd,
                            output logic er, output logic rv);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    rv = rvalid; rd = rdata; er = err;
  endtask

  task automatic reg_write(input string name, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; logic er; logic rv;
    bus_access(1'b1, a, d, 4'hF, rd, er, rv);
    check({name, "_resp"}, {62'd0, rv, er}, {62'd0, 1'b1, 1'b0});
  endtask

  task automatic reg_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic er; logic rv;
    bus_access(1'b0, a, 32'h0, 4'hF, rd, er, rv);
    check({name, "_resp"}, {62'd0, rv, er}, {62'd0, 1'b1, 1'b0});
    check({name, "_rdata"}, 64'(rd), 64'(exp));
  endtask

  // n back-to-back TXDATA writes, then one idle cycle; counts responses.
  task automatic write_burst(input int n, input logic [7:0] first,
                             output int n_rv, output int n_err);
    n_rv = 0; n_err = 0;
    @(posedge clk); #1;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        req = 1'b1; we = 1'b1; addr = 32'h0; be = 4'h1; wdata = 32'(first + 8'(i));
      end else begin
        bus_idle();
      end
      @(negedge clk);
      if (rvalid) n_rv++;
      if (err) n_err++;
      @(posedge clk); #1;
    end
  endtask

  // Called right after a TXDATA write returns (mid cycle N+1).
  task automatic capture_frame(input string name, input logic [7:0] b, input int div);
    logic [63:0] got;
    logic [63:0] exp;
    int p;
    got = '0; exp = '0;
    check({name, "_tx_before_start"}, 64'(tx), 64'd1);
    for (int i = 0; i < 10 * div; i++) begin
      @(negedge clk);
      if (i == 0) check({name, "_start_state"}, 64'(dbg_state), 64'(ST_START));
      p = i / div;
      got[i] = tx;
      exp[i] = (p == 0) ? 1'b0 : (p <= 8) ? b[p-1] : 1'b1;
    end
    check({name, "_bits"}, got, exp);
    @(negedge clk);
    check({name, "_after_tx"}, 64'(tx), 64'd1);
    check({name, "_after_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // ---------------------------------------------------- vector table
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b, input logic [31:0] er_d, input logic ee);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.be = b; v.exp_rdata = er_d; v.exp_err = ee;
    return v;
  endfunction

  // ---------------------------------------------------- test
  initial begin
    logic [31:0] rd;
    logic er, rv;
    int n_rv, n_err, cyc, lows;
    logic [7:0]  b0, b1, bb;
    logic [59:0] got_st, exp_st;
    logic [29:0] got_irq, exp_irq, got_tx, exp_tx, got_rv, exp_rv;
    logic [1:0]  es;
    logic        et;
    int p;

    vecs[0]  = mk(1'b0, 32'h4,         32'h0,        4'hF, 32'h2,    1'b0);
    vecs[1]  = mk(1'b0, 32'h8,         32'h0,        4'hF, 32'd868,  1'b0);
    vecs[2]  = mk(1'b0, 32'hC,         32'h0,        4'hF, 32'h0,    1'b0);
    vecs[3]  = mk(1'b0, 32'h0,         32'h0,        4'hF, 32'h0,    1'b0);
    vecs[4]  = mk(1'b1, 32'h8,         32'h1234,     4'hF, 32'h0,    1'b0);
    vecs[5]  = mk(1'b0, 32'h8,         32'h0,        4'hF, 32'h1234, 1'b0);
    vecs[6]  = mk(1'b1, 32'h8,         32'hFFFFABCD, 4'h1, 32'h0,    1'b0);
    vecs[7]  = mk(1'b0, 32'h8,         32'h0,        4'hF, 32'h12CD, 1'b0);
    vecs[8]  = mk(1'b1, 32'h8,         32'h00005600, 4'h2, 32'h0,    1'b0);
    vecs[9]  = mk(1'b0, 32'h8,         32'h0,        4'hF, 32'h56CD, 1'b0);
    vecs[10] = mk(1'b1, 32'h4,         32'hFFFFFFFF, 4'hF, 32'h0,    1'b0);
    vecs[11] = mk(1'b0, 32'h4,         32'h0,        4'hF, 32'h2,    1'b0);
    vecs[12] = mk(1'b0, 32'h10,        32'h0,        4'hF, 32'h0,    1'b1);
    vecs[13] = mk(1'b1, 32'h10,        32'h1,        4'hF, 32'h0,    1'b1);
    vecs[14] = mk(1'b0, 32'h3FC,       32'h0,        4'hF, 32'h0,    1'b1);
    vecs[15] = mk(1'b1, 32'h3FC,       32'h5,        4'hF, 32'h0,    1'b1);
    vecs[16] = mk(1'b0, 32'h8,         32'h0,        4'hF, 32'h56CD, 1'b0);
    vecs[17] = mk(1'b1, 32'hC,         32'h3,        4'hF, 32'h0,    1'b0);
    vecs[18] = mk(1'b0, 32'hC,         32'h0,        4'hF, 32'h1,    1'b0);
    vecs[19] = mk(1'b1, 32'hC,         32'h0,        4'hF, 32'h0,    1'b0);
    vecs[20] = mk(1'b0, 32'hC,         32'h0,        4'hF, 32'h0,    1'b0);
    vecs[21] = mk(1'b1, 32'h0,         32'hAB,       4'hE, 32'h0,    1'b0);
    vecs[22] = mk(1'b0, 32'h4,         32'h0,        4'hF, 32'h2,    1'b0);
    vecs[23] = mk(1'b0, 32'hFFFFF808,  32'h0,        4'hF, 32'h56CD, 1'b0);
    vecs[24] = mk(1'b0, 32'h7,         32'h0,        4'hF, 32'h2,    1'b0);
    vecs[25] = mk(1'b1, 32'h8,         32'h0,        4'hF, 32'h0,    1'b0);
    vecs[26] = mk(1'b0, 32'h8,         32'h0,        4'hF, 32'h0,    1'b0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_tx", 64'(tx), 64'd1);
    check("reset_irq", 64'(irq), 64'd0);
    check("reset_resp", {30'd0, rvalid, err, rdata}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));

    // Register access table.
    for (int i = 0; i < 27; i++) begin
      bus_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, rv);
      check($sformatf("vec%0d_rvalid", i), 64'(rv), 64'd1);
      check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
    end
    @(negedge clk);
    check("rvalid_idle", {31'd0, rvalid, rdata}, 64'd0);

    // CLKDIV=0 behaves as 1 cycle per bit.
    reg_write("wr_tx3c", 32'h0, 32'h3C);
    capture_frame("frame_div0", 8'h3C, 1);

    // Main frame, 4 cycles per bit.
    reg_write("wr_div4", 32'h8, 32'h4);
    reg_write("wr_txa5", 32'h0, 32'hA5);
    capture_frame("frame_a5", 8'hA5, 4);

    // Interrupt and back-to-back frames with one idle cycle between.
    reg_write("wr_div1", 32'h8, 32'h1);
    reg_write("wr_ctrl1", 32'hC, 32'h1);
    repeat (2) @(negedge clk);
    check("irq_idle_empty", 64'(irq), 64'd1);
    b0 = 8'h5A; b1 = 8'hC3;
    @(posedge clk); #1;
    for (int k = 0; k < 30; k++) begin
      if (k < 2) begin
        req = 1'b1; we = 1'b1; addr = 32'h0; be = 4'h1; wdata = 32'((k == 0) ? b0 : b1);
      end else begin
        bus_idle();
      end
      @(negedge clk);
      got_st[2*k +: 2] = dbg_state;
      got_irq[k] = irq;
      got_tx[k]  = tx;
      got_rv[k]  = rvalid;
      if (k < 2 || k == 12 || k >= 23) begin
        es = ST_IDLE; et = 1'b1;
      end else begin
        p  = (k < 12) ? k - 2 : k - 13;
        bb = (k < 12) ? b0 : b1;
        if (p == 0)      begin es = ST_START; et = 1'b0;    end
        else if (p <= 8) begin es = ST_DATA;  et = bb[p-1]; end
        else             begin es = 2'd3;     et = 1'b1;    end
      end
      exp_st[2*k +: 2] = es;
      exp_tx[k]  = et;
      exp_irq[k] = (k <= 1 || k >= 24);
      exp_rv[k]  = (k == 1 || k == 2);
      @(posedge clk); #1;
    end
    check("b2b_states", 64'(got_st), 64'(exp_st));
    check("b2b_tx", 64'(got_tx), 64'(exp_tx));
    check("b2b_irq", 64'(got_irq), 64'(exp_irq));
    check("b2b_rvalid", 64'(got_rv), 64'(exp_rv));

    // FIFO fill and overflow.
    reg_write("wr_div100", 32'h8, 32'd100);
    write_burst(9, 8'h10, n_rv, n_err);
    check("burst9_rvalid", 64'(n_rv), 64'd9);
    check("burst9_err", 64'(n_err), 64'd0);
    reg_read("status_full", 32'h4, 32'h805);
    write_burst(8, 8'h40, n_rv, n_err);
    check("burst8_rvalid", 64'(n_rv), 64'd8);
    check("burst8_err", 64'(n_err), 64'd0);
    reg_read("status_ovf", 32'h4, 32'h80D);
    reg_write("wr_ctrl_clr", 32'hC, 32'h2);
    reg_read("status_clr", 32'h4, 32'h805);

    // Reset in the middle of the data bits.
    cyc = 0;
    while (dbg_state != ST_DATA && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_data", 64'(dbg_state), 64'(ST_DATA));
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_tx", 64'(tx), 64'd1);
    check("rst_mid_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_mid_irq", 64'(irq), 64'd0);
    reg_read("rst_status", 32'h4, 32'h2);
    reg_read("rst_clkdiv", 32'h8, 32'd868);
    reg_read("rst_ctrl", 32'hC, 32'h0);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || dbg_state !== ST_IDLE) lows++;
    end
    check("rst_no_resume", 64'(lows), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
